// File: rtl/crypto_seq_pkg.sv
// crypto_seq_pkg: sequencer state encoding, command opcodes and a sizing helper.
package crypto_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, ECC_RUN, PUB_DONE, SESS_DONE, KEY_WAIT, FILL, STREAM, DRAIN, DES_DONE
  } state_t;
  localparam logic [1:0] OP_PUB  = 2'd0;
  localparam logic [1:0] OP_SESS = 2'd1;
  localparam logic [1:0] OP_DES  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/crypto_seq_cnt.sv
// crypto_seq_cnt: loadable down-counter that stops at zero and flags it.
module crypto_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/crypto_seq_ctrl.sv
// crypto_seq_ctrl: sequencer for ECC key generation and cipher key-wait/fill/stream/drain.
// Define CRYPTO_SEQ_TIMEOUT_EN to enable the ECC_RUN watchdog (err + return to IDLE).
module crypto_seq_ctrl
  import crypto_seq_pkg::*;
#(
  parameter int KEY_W        = 164,
  parameter int SESS_W       = 192,
  parameter int KEY_WAIT_CYC = 10,
  parameter int PIPE_LAT     = 48,
  parameter int ECC_TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              abort,
  output logic              ecc_start,
  input  logic              ecc_done,
  input  logic [KEY_W-1:0]  ecc_px,
  input  logic [KEY_W-1:0]  ecc_py,
  output logic [KEY_W-1:0]  pub_x,
  output logic [KEY_W-1:0]  pub_y,
  output logic [SESS_W-1:0] sess_key,
  input  logic              data_active,
  output logic              done_pub,
  output logic              done_sess,
  output logic              done_des,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(max3(KEY_WAIT_CYC, PIPE_LAT, ECC_TIMEOUT) + 1);
  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              err_q, err_d, done_des_q, done_des_d;
  logic [KEY_W-1:0]  pub_x_q, pub_x_d, pub_y_q, pub_y_d;
  logic [SESS_W-1:0] sess_q, sess_d;
  logic              cnt_ld, cnt_zero;
  logic [CW-1:0]     cnt_val;
  crypto_seq_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (cnt_ld),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    err_d      = err_q;
    done_des_d = done_des_q;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        op_d    = cmd_op;
        err_d   = cmd_op == OP_RSVD;
        state_d = cmd_op == OP_RSVD ? IDLE : cmd_op == OP_DES ? KEY_WAIT : ECC_RUN;
        done_des_d = cmd_op == OP_DES ? 1'b0 : done_des_q;
      end
    end else if (abort) state_d = IDLE;
    else
      case (state_q)
        ECC_RUN: begin
          if (ecc_done) state_d = op_q == OP_SESS ? SESS_DONE : PUB_DONE;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
          else if (cnt_zero) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
`endif
        end
        KEY_WAIT: state_d = cnt_zero ? FILL : state_q;
        FILL:     state_d = cnt_zero ? STREAM : state_q;
        STREAM:   state_d = data_active ? state_q : DRAIN;
        DRAIN:    state_d = cnt_zero ? DES_DONE : state_q;
        default:  state_d = IDLE;
      endcase
    // Results are captured as the done state is entered so they are valid alongside the pulse.
    pub_x_d    = state_q == ECC_RUN && state_d == PUB_DONE ? ecc_px : pub_x_q;
    pub_y_d    = state_q == ECC_RUN && state_d == PUB_DONE ? ecc_py : pub_y_q;
    sess_d     = state_q == ECC_RUN && state_d == SESS_DONE ?
                 {ecc_px[KEY_W-2:0], ecc_py[SESS_W-KEY_W:0]} : sess_q;
    done_des_d = state_d == DES_DONE ? 1'b1 : done_des_d;
    cnt_ld     = state_d != state_q;
    cnt_val    = state_d == ECC_RUN ? CW'(ECC_TIMEOUT - 1) :
                 state_d == KEY_WAIT ? CW'(KEY_WAIT_CYC - 1) :
                 (state_d == FILL || state_d == DRAIN) ? CW'(PIPE_LAT - 1) : '0;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q    <= IDLE;
      op_q       <= OP_PUB;
      err_q      <= 1'b0;
      done_des_q <= 1'b0;
      pub_x_q    <= '0;
      pub_y_q    <= '0;
      sess_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      err_q      <= err_d;
      done_des_q <= done_des_d;
      pub_x_q    <= pub_x_d;
      pub_y_q    <= pub_y_d;
      sess_q     <= sess_d;
    end
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign ecc_start = state_q == ECC_RUN;
  assign done_pub  = state_q == PUB_DONE;
  assign done_sess = state_q == SESS_DONE;
  assign done_des  = done_des_q;
  assign err       = err_q;
  assign pub_x     = pub_x_q;
  assign pub_y     = pub_y_q;
  assign sess_key  = sess_q;
endmodule
